// File: rtl/serial_add_pkg.sv
// Shared definitions for the bit-serial adder sequencer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package serial_add_pkg;

   // Default operand/result width
   localparam int DEF_WIDTH = 8;

   // State encodings, kept as plain 2-bit constants so other blocks can decode them
   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   typedef enum logic [1:0] {
      IDLE = ST_IDLE,
      RUN  = ST_RUN,
      DONE = ST_DONE
   } state_t;

   // Bit-counter width; it only ever has to reach width-1
   function automatic int cnt_width(input int width);
      return (width <= 2) ? 1 : $clog2(width);
   endfunction

endpackage

// File: rtl/serial_add_seq_sipo.sv
// Serial-in parallel-out right-shift register; new bit enters at the MSB.
// Latency: one clock per shift or load.
// Backpressure: none; shifts whenever shift_i is high, load_i has priority.
module shift_reg_sipo #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load_i,
   input  logic [WIDTH-1:0] load_dat_i,
   input  logic             shift_i,
   input  logic             ser_i,
   output logic [WIDTH-1:0] par_o
);

   logic [WIDTH-1:0] data_q;
   logic [WIDTH-1:0] data_d;

   // Next value: synchronous load wins over a shift, otherwise hold
   always_comb begin
      data_d = data_q;
      if (load_i) begin
         data_d = load_dat_i;
      end else if (shift_i) begin
         data_d = {ser_i, data_q[WIDTH-1:1]};
      end
   end

   // Storage with asynchronous clear
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data_q <= '0;
      end else begin
         data_q <= data_d;
      end
   end

   assign par_o = data_q;

endmodule

// File: rtl/serial_add_seq.sv
// Bit-serial adder sequencer driving an external 1-bit full adder LSB-first.
// Latency: start accepted at edge k -> done pulse in the cycle ending at edge k+WIDTH+1.
// Backpressure: start is only honoured in IDLE; requester holds it until busy rises.
module serial_add_seq
   import serial_add_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a_in,
   input  logic [WIDTH-1:0] b_in,
   input  logic             cin,
   output logic             fa_a,
   output logic             fa_b,
   output logic             fa_cin,
   input  logic             fa_s,
   input  logic             fa_c,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);

   localparam int                 CNT_W    = cnt_width(WIDTH);
   localparam logic [CNT_W-1:0]   LAST_CNT = CNT_W'(WIDTH - 1);

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_sh_q, a_sh_d;
   logic [WIDTH-1:0] b_sh_q, b_sh_d;
   logic             carry_q, carry_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] sum_q, sum_d;
   logic             cout_q, cout_d;
   logic             ovf_q, ovf_d;

   logic [WIDTH-1:0] s_sh;
   logic             s_load;
   logic             s_shift;

   // Sum bits collected from the full adder, LSB arrives first and ends at bit 0
   shift_reg_sipo #(
      .WIDTH (WIDTH)
   ) u_s_sh (
      .clk        (clk),
      .rst_n      (rst_n),
      .load_i     (s_load),
      .load_dat_i ({WIDTH{1'b0}}),
      .shift_i    (s_shift),
      .ser_i      (fa_s),
      .par_o      (s_sh)
   );

   // Sequencer: next state, datapath next values and full-adder drive
   always_comb begin
      state_d = state_q;
      a_sh_d  = a_sh_q;
      b_sh_d  = b_sh_q;
      carry_d = carry_q;
      cnt_d   = cnt_q;
      sum_d   = sum_q;
      cout_d  = cout_q;
      ovf_d   = ovf_q;
      s_load  = 1'b0;
      s_shift = 1'b0;
      fa_a    = 1'b0;
      fa_b    = 1'b0;
      fa_cin  = 1'b0;
      busy    = 1'b0;
      done    = 1'b0;

      case (state_q)
         IDLE: begin
            if (start) begin
               a_sh_d  = a_in;
               b_sh_d  = b_in;
               carry_d = cin;
               cnt_d   = '0;
               s_load  = 1'b1;
               state_d = RUN;
            end
         end

         RUN: begin
            busy    = 1'b1;
            fa_a    = a_sh_q[0];
            fa_b    = b_sh_q[0];
            fa_cin  = carry_q;
            s_shift = 1'b1;
            a_sh_d  = {1'b0, a_sh_q[WIDTH-1:1]};
            b_sh_d  = {1'b0, b_sh_q[WIDTH-1:1]};
            carry_d = fa_c;
            cnt_d   = cnt_q + CNT_W'(1);
            if (cnt_q == LAST_CNT) begin
               // carry_q is the carry into the MSB on this last bit
               sum_d   = {fa_s, s_sh[WIDTH-1:1]};
               cout_d  = fa_c;
               ovf_d   = carry_q ^ fa_c;
               cnt_d   = '0;
               state_d = DONE;
            end
         end

         DONE: begin
            busy    = 1'b1;
            done    = 1'b1;
            state_d = IDLE;
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and datapath registers; reset aborts any operation in flight
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         a_sh_q  <= '0;
         b_sh_q  <= '0;
         carry_q <= 1'b0;
         cnt_q   <= '0;
         sum_q   <= '0;
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         a_sh_q  <= a_sh_d;
         b_sh_q  <= b_sh_d;
         carry_q <= carry_d;
         cnt_q   <= cnt_d;
         sum_q   <= sum_d;
         cout_q  <= cout_d;
         ovf_q   <= ovf_d;
      end
   end

   assign sum  = sum_q;
   assign cout = cout_q;
   assign ovf  = ovf_q;

endmodule

// File: tb/tb_serial_add_seq.sv
// Directed bench for serial_add_seq with a behavioural 1-bit full adder.
// Latency: checks done arrives 9 cycles after the start edge for WIDTH=8.
// Backpressure: exercises start being ignored during RUN and DONE.
module tb_serial_add_seq;

   localparam int W = 8;

   logic         clk;
   logic         rst_n;
   logic         start;
   logic [W-1:0] a_in;
   logic [W-1:0] b_in;
   logic         cin;
   logic         fa_a, fa_b, fa_cin, fa_s, fa_c;
   logic         busy, done, cout, ovf;
   logic [W-1:0] sum;

   int n_pass  = 0;
   int n_total = 0;

   serial_add_seq #(.WIDTH(W)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .start  (start),
      .a_in   (a_in),
      .b_in   (b_in),
      .cin    (cin),
      .fa_a   (fa_a),
      .fa_b   (fa_b),
      .fa_cin (fa_cin),
      .fa_s   (fa_s),
      .fa_c   (fa_c),
      .busy   (busy),
      .done   (done),
      .sum    (sum),
      .cout   (cout),
      .ovf    (ovf)
   );

   // Full-adder cell
   assign fa_s = fa_a ^ fa_b ^ fa_cin;
   assign fa_c = (fa_a & fa_b) | (fa_cin & (fa_a ^ fa_b));

   initial clk = 1'b0;
   always #10 clk = ~clk;

   // Present operands with start across one rising edge
   task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
      @(negedge clk);
      a_in  = a;
      b_in  = b;
      cin   = c;
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
   endtask

   // Count negedges until done is seen (bounded)
   task automatic wait_done(output int n);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!done && n < 30);
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      start = 1'b0;
      a_in  = '0;
      b_in  = '0;
      cin   = 1'b0;
      repeat (3) @(negedge clk);
      n_total++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else n_pass++;
      n_total++; if (done !== 1'b0) $display("FAIL reset_done got %b want 0", done); else n_pass++;
      n_total++; if (sum !== 8'h00) $display("FAIL reset_sum got %h want 00", sum); else n_pass++;
      n_total++; if (cout !== 1'b0) $display("FAIL reset_cout got %b want 0", cout); else n_pass++;
      n_total++; if (ovf !== 1'b0) $display("FAIL reset_ovf got %b want 0", ovf); else n_pass++;
      n_total++; if ({fa_a, fa_b, fa_cin} !== 3'b000) $display("FAIL reset_fa got %b want 000", {fa_a, fa_b, fa_cin}); else n_pass++;
      rst_n = 1'b1;
      @(negedge clk);
      n_total++; if (busy !== 1'b0) $display("FAIL idle_busy got %b want 0", busy); else n_pass++;
   endtask

   task automatic test_basic;
      int n;
      launch(8'h0F, 8'h01, 1'b0);
      wait_done(n);
      n_total++; if (n !== 9) $display("FAIL basic_latency got %0d want 9", n); else n_pass++;
      n_total++; if (sum !== 8'h10) $display("FAIL basic_sum got %h want 10", sum); else n_pass++;
      n_total++; if (cout !== 1'b0) $display("FAIL basic_cout got %b want 0", cout); else n_pass++;
      n_total++; if (ovf !== 1'b0) $display("FAIL basic_ovf got %b want 0", ovf); else n_pass++;
      n_total++; if (busy !== 1'b1) $display("FAIL basic_busy_done got %b want 1", busy); else n_pass++;
      @(negedge clk);
      n_total++; if (done !== 1'b0) $display("FAIL basic_done_pulse got %b want 0", done); else n_pass++;
      n_total++; if (sum !== 8'h10) $display("FAIL basic_sum_hold got %h want 10", sum); else n_pass++;
   endtask

   task automatic test_wrap;
      int n;
      launch(8'hFF, 8'h01, 1'b0);
      wait_done(n);
      n_total++; if (sum !== 8'h00) $display("FAIL wrap_sum got %h want 00", sum); else n_pass++;
      n_total++; if (cout !== 1'b1) $display("FAIL wrap_cout got %b want 1", cout); else n_pass++;
      n_total++; if (ovf !== 1'b0) $display("FAIL wrap_ovf got %b want 0", ovf); else n_pass++;
   endtask

   task automatic test_overflow;
      int n;
      launch(8'h7F, 8'h01, 1'b0);
      wait_done(n);
      n_total++; if (sum !== 8'h80) $display("FAIL ovf_pos_sum got %h want 80", sum); else n_pass++;
      n_total++; if (cout !== 1'b0) $display("FAIL ovf_pos_cout got %b want 0", cout); else n_pass++;
      n_total++; if (ovf !== 1'b1) $display("FAIL ovf_pos_ovf got %b want 1", ovf); else n_pass++;
      launch(8'h80, 8'h80, 1'b0);
      wait_done(n);
      n_total++; if (sum !== 8'h00) $display("FAIL ovf_neg_sum got %h want 00", sum); else n_pass++;
      n_total++; if (cout !== 1'b1) $display("FAIL ovf_neg_cout got %b want 1", cout); else n_pass++;
      n_total++; if (ovf !== 1'b1) $display("FAIL ovf_neg_ovf got %b want 1", ovf); else n_pass++;
   endtask

   task automatic test_cin;
      int n;
      launch(8'h00, 8'h00, 1'b1);
      @(negedge clk);
      n_total++; if (fa_cin !== 1'b1) $display("FAIL cin_fa_cin got %b want 1", fa_cin); else n_pass++;
      n_total++; if (busy !== 1'b1) $display("FAIL cin_busy got %b want 1", busy); else n_pass++;
      wait_done(n);
      n_total++; if (n !== 8) $display("FAIL cin_latency got %0d want 8", n); else n_pass++;
      n_total++; if (sum !== 8'h01) $display("FAIL cin_sum got %h want 01", sum); else n_pass++;
      launch(8'hFF, 8'h00, 1'b1);
      @(negedge clk);
      n_total++; if (fa_a !== 1'b1) $display("FAIL cin2_fa_a got %b want 1", fa_a); else n_pass++;
      wait_done(n);
      n_total++; if (sum !== 8'h00) $display("FAIL cin2_sum got %h want 00", sum); else n_pass++;
      n_total++; if (cout !== 1'b1) $display("FAIL cin2_cout got %b want 1", cout); else n_pass++;
      n_total++; if (ovf !== 1'b0) $display("FAIL cin2_ovf got %b want 0", ovf); else n_pass++;
   endtask

   task automatic test_restart_ignored;
      int n;
      launch(8'h12, 8'h34, 1'b0);
      repeat (3) @(negedge clk);
      a_in  = 8'hAA;
      b_in  = 8'h55;
      cin   = 1'b1;
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      wait_done(n);
      n_total++; if (n !== 6) $display("FAIL restart_latency got %0d want 6", n); else n_pass++;
      n_total++; if (sum !== 8'h46) $display("FAIL restart_run_sum got %h want 46", sum); else n_pass++;
      n_total++; if (cout !== 1'b0) $display("FAIL restart_run_cout got %b want 0", cout); else n_pass++;
      // start during the DONE cycle must not be captured either
      a_in  = 8'hFF;
      b_in  = 8'hFF;
      cin   = 1'b1;
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      @(negedge clk);
      n_total++; if (busy !== 1'b0) $display("FAIL restart_done_busy got %b want 0", busy); else n_pass++;
      repeat (3) @(negedge clk);
      n_total++; if (busy !== 1'b0) $display("FAIL restart_done_idle got %b want 0", busy); else n_pass++;
      n_total++; if (sum !== 8'h46) $display("FAIL restart_done_sum got %h want 46", sum); else n_pass++;
   endtask

   task automatic test_reset_mid_run;
      int n;
      int done_seen;
      launch(8'hF0, 8'h01, 1'b0);
      repeat (5) @(negedge clk);
      n_total++; if (fa_a !== 1'b1) $display("FAIL midrst_fa_a_before got %b want 1", fa_a); else n_pass++;
      rst_n = 1'b0;
      #1;
      n_total++; if (busy !== 1'b0) $display("FAIL midrst_busy got %b want 0", busy); else n_pass++;
      n_total++; if (sum !== 8'h00) $display("FAIL midrst_sum got %h want 00", sum); else n_pass++;
      n_total++; if (fa_a !== 1'b0) $display("FAIL midrst_fa_a got %b want 0", fa_a); else n_pass++;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      done_seen = 0;
      repeat (15) begin
         @(negedge clk);
         if (done) done_seen++;
      end
      n_total++; if (done_seen !== 0) $display("FAIL midrst_no_done got %0d want 0", done_seen); else n_pass++;
      n_total++; if (sum !== 8'h00) $display("FAIL midrst_sum_after got %h want 00", sum); else n_pass++;
      launch(8'h55, 8'h2A, 1'b1);
      wait_done(n);
      n_total++; if (n !== 9) $display("FAIL fresh_latency got %0d want 9", n); else n_pass++;
      n_total++; if (sum !== 8'h80) $display("FAIL fresh_sum got %h want 80", sum); else n_pass++;
      n_total++; if (cout !== 1'b0) $display("FAIL fresh_cout got %b want 0", cout); else n_pass++;
      n_total++; if (ovf !== 1'b1) $display("FAIL fresh_ovf got %b want 1", ovf); else n_pass++;
   endtask

   initial begin
      test_reset();
      test_basic();
      test_wrap();
      test_overflow();
      test_cin();
      test_restart_ignored();
      test_reset_mid_run();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
